// File: rtl/gate_bist_pkg.sv
// Shared types, widths and golden response for the gate-bank self-test.
package gate_bist_pkg;

   localparam int VEC_W  = 3;
   localparam int GATE_W = 6;

   localparam int GB_AND  = 5;
   localparam int GB_OR   = 4;
   localparam int GB_NAND = 3;
   localparam int GB_NOR  = 2;
   localparam int GB_XOR  = 1;
   localparam int GB_XNOR = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [GATE_W-1:0] expected_resp(input logic [VEC_W-1:0] v);
      logic [GATE_W-1:0] r;
      r          = '0;
      r[GB_AND]  = &v;
      r[GB_OR]   = |v;
      r[GB_NAND] = ~&v;
      r[GB_NOR]  = ~|v;
      r[GB_XOR]  = ^v;
      r[GB_XNOR] = ~^v;
      return r;
   endfunction

endpackage

// File: rtl/gate_bist_ref.sv
// Combinational golden response of an ideal 3-input gate bank.
module gate_bist_ref
   import gate_bist_pkg::*;
(
   input  logic [VEC_W-1:0]  vec,
   output logic [GATE_W-1:0] resp
);

   assign resp = expected_resp(vec);

endmodule

// File: rtl/gate_bist.sv
// Walks all 8 input vectors through the gate bank and scores the responses.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; results of last run held
//   ST_HOLD | driving vec_o, hold counter counts down, sample at zero
//   ST_DONE | one-cycle done pulse, pass valid, then back to idle
module gate_bist
   import gate_bist_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [VEC_W-1:0]  vec_o,
   input  logic [GATE_W-1:0] gate_i,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [3:0]        err_count,
   output logic [VEC_W-1:0]  fail_vec,
   output logic              fail_valid
);

   localparam logic [3:0] HOLD_LOAD = 4'(SETTLE_CYCLES);

   state_t            state;
   logic [3:0]        hold_cnt;
   logic [GATE_W-1:0] exp_resp;
   logic              mismatch;
   logic [3:0]        err_next;

   gate_bist_ref u_ref (
      .vec  (vec_o),
      .resp (exp_resp)
   );

   assign mismatch = (gate_i != exp_resp);
   assign err_next = mismatch ? err_count + 4'd1 : err_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         hold_cnt   <= 4'd0;
         vec_o      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= 4'd0;
         fail_vec   <= '0;
         fail_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state      <= ST_HOLD;
                  hold_cnt   <= HOLD_LOAD;
                  vec_o      <= '0;
                  busy       <= 1'b1;
                  pass       <= 1'b0;
                  err_count  <= 4'd0;
                  fail_vec   <= '0;
                  fail_valid <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (hold_cnt != 4'd0) begin
                  hold_cnt <= hold_cnt - 4'd1;
               end else begin
                  // terminal count: this edge is the sample point of the window
                  err_count <= err_next;
                  if (mismatch && !fail_valid) begin
                     fail_vec   <= vec_o;
                     fail_valid <= 1'b1;
                  end
                  if (vec_o == '1) begin
                     state <= ST_DONE;
                     vec_o <= '0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_next == 4'd0);
                  end else begin
                     vec_o    <= vec_o + 1'b1;
                     hold_cnt <= HOLD_LOAD;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_bist.sv
// Self-checking bench for gate_bist: two instances (settle 1 and settle 0) with modelled gate banks.
module tb_gate_bist;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       start1 = 1'b0, start0 = 1'b0;
   logic [5:0] gate1, gate0;
   logic [2:0] vec1, vec0, fv1, fv0;
   logic       busy1, busy0, done1, done0, pass1, pass0, fval1, fval0;
   logic [3:0] err1, err0;

   gate_bist #(.SETTLE_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start1), .vec_o(vec1), .gate_i(gate1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .fail_vec(fv1), .fail_valid(fval1)
   );

   gate_bist #(.SETTLE_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .vec_o(vec0), .gate_i(gate0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
      .fail_vec(fv0), .fail_valid(fval0)
   );

   int checks = 0;
   int failures = 0;

   // bank mode: 0 ideal ^ fault mask, 1 xor stuck at 0, 2 all outputs 0, 3 one-cycle delayed
   int         mode = 0;
   int         use_s0 = 0;
   logic [5:0] fmask [8];
   logic [5:0] dly1 = 6'd0, dly0 = 6'd0;

   // ideal bank from truth-table reasoning: {and, or, nand, nor, xor, xnor}
   function automatic logic [5:0] ideal(input int v);
      int   ones;
      logic a, o, x;
      ones = (v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1);
      a = (ones == 3);
      o = (ones != 0);
      x = (ones % 2 == 1);
      return {a, o, !a, !o, x, !x};
   endfunction

   always @(posedge clk) begin
      dly1 <= ideal(int'(vec1));
      dly0 <= ideal(int'(vec0));
   end

   always_comb begin
      gate1 = ideal(int'(vec1));
      case (mode)
         0: gate1 = ideal(int'(vec1)) ^ fmask[vec1];
         1: gate1 = ideal(int'(vec1)) & 6'b111101;
         2: gate1 = 6'b000000;
         3: gate1 = dly1;
         default: gate1 = ideal(int'(vec1));
      endcase
   end
   assign gate0 = dly0;

   logic [2:0] m_vec, m_fv;
   logic       m_busy, m_done, m_pass, m_fval;
   logic [3:0] m_err;
   assign m_vec  = use_s0 != 0 ? vec0  : vec1;
   assign m_fv   = use_s0 != 0 ? fv0   : fv1;
   assign m_busy = use_s0 != 0 ? busy0 : busy1;
   assign m_done = use_s0 != 0 ? done0 : done1;
   assign m_pass = use_s0 != 0 ? pass0 : pass1;
   assign m_fval = use_s0 != 0 ? fval0 : fval1;
   assign m_err  = use_s0 != 0 ? err0  : err1;

   // Expected outcome of a whole run: what the bank shows at each sample point vs. the ideal.
   task automatic model(input int s, output int e, output logic [2:0] fv, output logic fval);
      logic [5:0] resp;
      e = 0; fv = 3'd0; fval = 1'b0;
      for (int v = 0; v < 8; v++) begin
         case (mode)
            0: resp = ideal(v) ^ fmask[v];
            1: resp = ideal(v) & 6'b111101;
            2: resp = 6'b000000;
            default: resp = (s == 0) ? ideal(v == 0 ? 0 : v - 1) : ideal(v);
         endcase
         if (resp != ideal(v)) begin
            e++;
            if (!fval) begin
               fv = 3'(v);
               fval = 1'b1;
            end
         end
      end
   endtask

   task automatic set_start(input logic val);
      if (use_s0 != 0) start0 = val;
      else start1 = val;
   endtask

   task automatic run_check(input int s, input string name, output int e_out);
      int         e, win;
      logic [2:0] fv;
      logic       fval;
      model(s, e, fv, fval);
      e_out = e;
      win = 8 * (s + 1);
      @(negedge clk); set_start(1'b1);
      @(negedge clk); set_start(1'b0);
      for (int k = 1; k <= win; k++) begin
         checks++;
         if (m_busy !== 1'b1 || m_done !== 1'b0 || m_vec !== 3'((k - 1) / (s + 1))) begin
            failures++;
            $display("FAIL %s cycle %0d: busy=%b done=%b vec=%0d, required busy=1 done=0 vec=%0d",
                     name, k, m_busy, m_done, m_vec, (k - 1) / (s + 1));
         end
         @(negedge clk);
      end
      checks++;
      if (m_done !== 1'b1 || m_busy !== 1'b0 || m_vec !== 3'd0) begin
         failures++;
         $display("FAIL %s done_cycle: done=%b busy=%b vec=%0d, required done=1 busy=0 vec=0",
                  name, m_done, m_busy, m_vec);
      end
      checks++;
      if (m_err !== 4'(e) || m_pass !== (e == 0) || m_fval !== fval || m_fv !== fv) begin
         failures++;
         $display("FAIL %s results: err=%0d pass=%b fval=%b fvec=%0d, required err=%0d pass=%b fval=%b fvec=%0d",
                  name, m_err, m_pass, m_fval, m_fv, e, (e == 0), fval, fv);
      end
      @(negedge clk);
      checks++;
      if (m_done !== 1'b0 || m_busy !== 1'b0 || m_err !== 4'(e) || m_pass !== (e == 0) ||
          m_fval !== fval || m_fv !== fv) begin
         failures++;
         $display("FAIL %s idle_hold: done=%b busy=%b err=%0d pass=%b, required done=0 busy=0 err=%0d pass=%b",
                  name, m_done, m_busy, m_err, m_pass, e, (e == 0));
      end
   endtask

   task automatic clear_masks();
      for (int v = 0; v < 8; v++) fmask[v] = 6'd0;
   endtask

   task automatic check_reset_vals(input string name);
      checks++;
      if (vec1 !== 3'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b0 ||
          err1 !== 4'd0 || fv1 !== 3'd0 || fval1 !== 1'b0) begin
         failures++;
         $display("FAIL %s: vec=%0d busy=%b done=%b pass=%b err=%0d fvec=%0d fval=%b, required all zero",
                  name, vec1, busy1, done1, pass1, err1, fv1, fval1);
      end
   endtask

   task automatic test_reset();
      #1;
      check_reset_vals("reset_state");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_idle_ignore();
      use_s0 = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (busy1 !== 1'b0 || done1 !== 1'b0 || vec1 !== 3'd0) begin
            failures++;
            $display("FAIL idle_no_start: busy=%b done=%b vec=%0d, required 0 0 0", busy1, done1, vec1);
         end
      end
   endtask

   task automatic test_golden();
      int e;
      use_s0 = 0; mode = 0; clear_masks();
      run_check(1, "golden", e);
   endtask

   task automatic test_stuck_xor();
      int e;
      use_s0 = 0; mode = 1;
      run_check(1, "stuck_xor", e);
      checks++;
      if (err1 !== 4'd4 || fv1 !== 3'b001) begin
         failures++;
         $display("FAIL stuck_xor_fixed: err=%0d fvec=%0d, required err=4 fvec=1", err1, fv1);
      end
   endtask

   task automatic test_all_fail();
      int e;
      use_s0 = 0; mode = 2;
      run_check(1, "all_fail", e);
      checks++;
      if (err1 !== 4'd8 || fv1 !== 3'd0 || pass1 !== 1'b0) begin
         failures++;
         $display("FAIL all_fail_fixed: err=%0d fvec=%0d pass=%b, required err=8 fvec=0 pass=0", err1, fv1, pass1);
      end
   endtask

   task automatic test_settle();
      int e;
      mode = 3;
      use_s0 = 1;
      run_check(0, "settle0_delayed", e);
      checks++;
      if (err0 === 4'd0) begin
         failures++;
         $display("FAIL settle0_nonzero: err=%0d, required nonzero", err0);
      end
      use_s0 = 0;
      run_check(1, "settle1_delayed", e);
      checks++;
      if (pass1 !== 1'b1) begin
         failures++;
         $display("FAIL settle1_pass: pass=%b, required 1", pass1);
      end
   endtask

   task automatic test_random();
      int e;
      use_s0 = 0; mode = 0;
      for (int it = 0; it < 6; it++) begin
         for (int v = 0; v < 8; v++)
            fmask[v] = ($urandom_range(0, 1) != 0) ? 6'($urandom) : 6'd0;
         run_check(1, "random_faults", e);
      end
      clear_masks();
   endtask

   task automatic test_start_hold();
      int  dones;
      bit  seen;
      use_s0 = 0; mode = 1; dones = 0;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 17; k++) begin
         if (done1 === 1'b1) dones++;
         if (k == 17) begin
            checks++;
            if (done1 !== 1'b1 || err1 !== 4'd4) begin
               failures++;
               $display("FAIL hold_start_done: done=%b err=%0d, required done=1 err=4", done1, err1);
            end
         end
         @(negedge clk);
      end
      mode = 0; clear_masks();
      if (done1 === 1'b1) dones++;
      checks++;
      if (busy1 !== 1'b0 || done1 !== 1'b0 || err1 !== 4'd4 || dones != 1) begin
         failures++;
         $display("FAIL hold_start_idle: busy=%b done=%b err=%0d dones=%0d, required 0 0 4 1",
                  busy1, done1, err1, dones);
      end
      @(negedge clk); start1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1 || err1 !== 4'd0 || fval1 !== 1'b0 || pass1 !== 1'b0 || vec1 !== 3'd0) begin
         failures++;
         $display("FAIL hold_start_relaunch: busy=%b err=%0d fval=%b pass=%b vec=%0d, required 1 0 0 0 0",
                  busy1, err1, fval1, pass1, vec1);
      end
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (done1 === 1'b1) seen = 1;
      end
      checks++;
      if (!seen || pass1 !== 1'b1 || err1 !== 4'd0) begin
         failures++;
         $display("FAIL hold_start_second_run: done_seen=%0d pass=%b err=%0d, required 1 1 0", seen, pass1, err1);
      end
      @(negedge clk);
   endtask

   task automatic test_abort();
      int e;
      use_s0 = 0; mode = 0; clear_masks();
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (vec1 !== 3'b101 || busy1 !== 1'b1) begin
         failures++;
         $display("FAIL abort_at_vec5: vec=%0d busy=%b, required vec=5 busy=1", vec1, busy1);
      end
      rst_n = 1'b0;
      #1;
      check_reset_vals("abort_immediate");
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL abort_quiet cycle %0d: busy=%b done=%b, required 0 0", k, busy1, done1);
         end
      end
      run_check(1, "after_abort", e);
   endtask

   initial begin
      clear_masks();
      test_reset();
      test_idle_ignore();
      test_golden();
      test_stuck_xor();
      test_all_fail();
      test_settle();
      test_random();
      test_start_hold();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
